// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared encodings and types for the RV32I writeback stage
//
// Writeback select encodings, load funct3 codes, the struct holding the
// registered MEM-stage fields, and a PC+4 helper.

package wb_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;

  typedef struct packed {
    logic [31:0] pc;
    logic        rd_wen;
    logic [4:0]  rd_waddr;
    logic [1:0]  wb_sel;
    logic [31:0] alu_res;
    logic [31:0] imm;
    logic [2:0]  funct3;
  } wb_fields_t;

  // Link address; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB bundle feeding the writeback stage
//
// master: MEM stage / memory side (drives all signals)
// slave : wb_stage (samples all signals)
//   i_valid, i_stall, i_flush       pipeline control
//   i_pc, i_rd_wen, i_rd_waddr      instruction identity and destination
//   i_wb_sel, i_alu_res, i_imm      writeback source selection and operands
//   i_funct3                        load type
//   i_dmem_rdata                    load word, arrives in the WB cycle

interface wb_stage_if;
  logic        i_valid;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_pc;
  logic        i_rd_wen;
  logic [4:0]  i_rd_waddr;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_res;
  logic [31:0] i_imm;
  logic [2:0]  i_funct3;
  logic [31:0] i_dmem_rdata;

  modport master (
    output i_valid, i_stall, i_flush, i_pc, i_rd_wen, i_rd_waddr,
           i_wb_sel, i_alu_res, i_imm, i_funct3, i_dmem_rdata
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_pc, i_rd_wen, i_rd_waddr,
           i_wb_sel, i_alu_res, i_imm, i_funct3, i_dmem_rdata
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - combinational load byte-lane alignment and extension
//
// Ports:
//   word        in  32  raw memory word
//   offset      in  2   byte offset within the word
//   funct3      in  3   load type (LB/LH/LW/LBU/LHU; 3,6,7 behave as LW)
//   data        out 32  aligned, extended load value
//   misaligned  out 1   access does not fit the given offset
// Parameter MISALIGN_CHK: 1 flags LH/LHU at offset 1 and LW at offset!=0.
// A halfword at offset 3 would straddle the word, so it is always flagged.

module wb_stage_load_align
  import wb_stage_pkg::*;
#(
  parameter int MISALIGN_CHK = 1
) (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Selected lane lands in the low bits.
  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      FUNCT3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_LBU: data = {24'h000000, shifted[7:0]};
      FUNCT3_LH: begin
        data       = {{16{shifted[15]}}, shifted[15:0]};
        misaligned = (offset == 2'd3) || ((MISALIGN_CHK != 0) && (offset == 2'd1));
      end
      FUNCT3_LHU: begin
        data       = {16'h0000, shifted[15:0]};
        misaligned = (offset == 2'd3) || ((MISALIGN_CHK != 0) && (offset == 2'd1));
      end
      default: begin
        data       = word;
        misaligned = (MISALIGN_CHK != 0) && (offset != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: result register, load align, rf write port
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   mem (wb_stage_if.slave)   MEM-stage fields, stall/flush, dmem read word
//   o_rd_wen/waddr/wdata      register file write port
//   o_valid, o_pc             WB slot status
//   o_misaligned              one-cycle pulse on a misaligned load
//   o_retire_cnt              retired instruction count (WB_RETIRE_CNT_EN only)
// Optional feature macro: WB_RETIRE_CNT_EN.

module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int MISALIGN_CHK = 1,
  parameter int RETIRE_W     = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  wb_stage_if.slave   mem,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic        o_misaligned
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] o_retire_cnt
`endif
);

  logic       valid_q;
  logic       written_q;
  wb_fields_t f_q;

  logic [31:0] load_data;
  logic        load_mis;
  logic        first_slot;
  logic        mis;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      written_q <= 1'b0;
      f_q       <= '0;
    end else if (mem.i_flush) begin
      valid_q   <= 1'b0;
      written_q <= 1'b0;
    end else if (mem.i_stall) begin
      // The held instruction already had its write cycle; block repeats.
      written_q <= written_q | valid_q;
    end else begin
      valid_q        <= mem.i_valid;
      written_q      <= 1'b0;
      f_q.pc         <= mem.i_pc;
      f_q.rd_wen     <= mem.i_rd_wen;
      f_q.rd_waddr   <= mem.i_rd_waddr;
      f_q.wb_sel     <= mem.i_wb_sel;
      f_q.alu_res    <= mem.i_alu_res;
      f_q.imm        <= mem.i_imm;
      f_q.funct3     <= mem.i_funct3;
    end
  end

  wb_stage_load_align #(
    .MISALIGN_CHK(MISALIGN_CHK)
  ) u_load_align (
    .word       (mem.i_dmem_rdata),
    .offset     (f_q.alu_res[1:0]),
    .funct3     (f_q.funct3),
    .data       (load_data),
    .misaligned (load_mis)
  );

  assign first_slot = valid_q & ~written_q;
  assign mis        = first_slot & (f_q.wb_sel == WB_SEL_LOAD) & load_mis;

  assign o_misaligned = mis;
  assign o_rd_wen     = first_slot & f_q.rd_wen & (f_q.rd_waddr != 5'd0) & ~mis;
  assign o_rd_waddr   = f_q.rd_waddr;
  assign o_valid      = valid_q;
  assign o_pc         = f_q.pc;

  always_comb begin
    o_rd_wdata = f_q.alu_res;
    case (f_q.wb_sel)
      WB_SEL_ALU:  o_rd_wdata = f_q.alu_res;
      WB_SEL_LOAD: o_rd_wdata = load_data;
      WB_SEL_PC4:  o_rd_wdata = pc_plus4(f_q.pc);
      WB_SEL_IMM:  o_rd_wdata = f_q.imm;
      default:     o_rd_wdata = f_q.alu_res;
    endcase
  end

`ifdef WB_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retire_cnt_q;

  // Counts each instruction once, in its first WB cycle, misaligned included.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      retire_cnt_q <= '0;
    end else if (first_slot) begin
      retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
    end
  end

  assign o_retire_cnt = retire_cnt_q;
`else
  logic [RETIRE_W-1:0] unused_retire_w;
  assign unused_retire_w = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage (checked and unchecked misalignment builds)

`timescale 1ns/1ps

module tb_wb_stage;

  typedef struct packed {
    logic        valid;
    logic        rd_wen;
    logic [4:0]  waddr;
    logic [1:0]  sel;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [31:0] rdata;
  } ins_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  wb_stage_if mif0 ();
  wb_stage_if mif1 ();

  logic        o0_wen, o1_wen, o0_valid, o1_valid, o0_mis, o1_mis;
  logic [4:0]  o0_waddr, o1_waddr;
  logic [31:0] o0_wdata, o1_wdata, o0_pc, o1_pc;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] o0_cnt, o1_cnt;
`endif

  wb_stage #(.MISALIGN_CHK(1), .RETIRE_W(64)) u_dut0 (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .mem          (mif0),
    .o_rd_wen     (o0_wen),
    .o_rd_waddr   (o0_waddr),
    .o_rd_wdata   (o0_wdata),
    .o_valid      (o0_valid),
    .o_pc         (o0_pc),
    .o_misaligned (o0_mis)
`ifdef WB_RETIRE_CNT_EN
    ,
    .o_retire_cnt (o0_cnt)
`endif
  );

  wb_stage #(.MISALIGN_CHK(0), .RETIRE_W(64)) u_dut1 (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .mem          (mif1),
    .o_rd_wen     (o1_wen),
    .o_rd_waddr   (o1_waddr),
    .o_rd_wdata   (o1_wdata),
    .o_valid      (o1_valid),
    .o_pc         (o1_pc),
    .o_misaligned (o1_mis)
`ifdef WB_RETIRE_CNT_EN
    ,
    .o_retire_cnt (o1_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model: the instruction sitting in WB and how many cycles it has been there.
  ins_t        m_ins = '0;
  bit          m_valid = 1'b0;
  int          m_age = 0;
  logic [63:0] m_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_byte(input logic [31:0] w, input int k);
    return (k < 4) ? ((w >> (8 * k)) & 32'hFF) : 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input int off, input logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    b = m_byte(w, off);
    h = b + 32'd256 * m_byte(w, off + 1);
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit m_misal(input int off, input logic [2:0] f3, input int chk_on);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (off == 3) || (chk_on != 0 && off == 1);
    return (chk_on != 0) && (off != 0);
  endfunction

  task automatic check_dut(input string tag, input int chk_on, input logic wen, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic val, input logic [31:0] pc, input logic mis);
    bit          first;
    bit          e_mis;
    bit          e_wen;
    logic [31:0] e_wdata;
    int          off;
    off   = int'(m_ins.alu[1:0]);
    first = m_valid && (m_age == 0);
    e_mis = first && (m_ins.sel == 2'b01) && m_misal(off, m_ins.f3, chk_on);
    e_wen = first && m_ins.rd_wen && (m_ins.waddr != 5'd0) && !e_mis;
    case (m_ins.sel)
      2'b00:   e_wdata = m_ins.alu;
      2'b01:   e_wdata = m_load(m_ins.rdata, off, m_ins.f3);
      2'b10:   e_wdata = m_ins.pc + 32'd4;
      default: e_wdata = m_ins.imm;
    endcase
    chk({tag, "_wen"},   64'(wen),   64'(e_wen));
    chk({tag, "_waddr"}, 64'(waddr), 64'(m_ins.waddr));
    chk({tag, "_wdata"}, 64'(wdata), 64'(e_wdata));
    chk({tag, "_valid"}, 64'(val),   64'(m_valid));
    chk({tag, "_pc"},    64'(pc),    64'(m_ins.pc));
    chk({tag, "_mis"},   64'(mis),   64'(e_mis));
  endtask

  always @(negedge i_clk) begin
    if (cmp_en) begin
      check_dut("d0", 1, o0_wen, o0_waddr, o0_wdata, o0_valid, o0_pc, o0_mis);
      check_dut("d1", 0, o1_wen, o1_waddr, o1_wdata, o1_valid, o1_pc, o1_mis);
`ifdef WB_RETIRE_CNT_EN
      chk("d0_cnt", o0_cnt, m_cnt);
      chk("d1_cnt", o1_cnt, m_cnt);
`endif
    end
  end

  function automatic ins_t mk(input logic v, input logic we, input logic [4:0] wa, input logic [1:0] sel,
                              input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] imm,
                              input logic [2:0] f3, input logic [31:0] rdata);
    ins_t r;
    r.valid = v; r.rd_wen = we; r.waddr = wa; r.sel = sel; r.pc = pc;
    r.alu = alu; r.imm = imm; r.f3 = f3; r.rdata = rdata;
    return r;
  endfunction

  // One pipeline cycle: present MEM inputs, clock, advance model, return load data.
  task automatic step(input ins_t m, input bit st = 1'b0, input bit fl = 1'b0, input bit rs = 1'b0);
    i_rst = rs;
    mif0.i_valid = m.valid;  mif1.i_valid = m.valid;
    mif0.i_stall = st;       mif1.i_stall = st;
    mif0.i_flush = fl;       mif1.i_flush = fl;
    mif0.i_pc = m.pc;        mif1.i_pc = m.pc;
    mif0.i_rd_wen = m.rd_wen; mif1.i_rd_wen = m.rd_wen;
    mif0.i_rd_waddr = m.waddr; mif1.i_rd_waddr = m.waddr;
    mif0.i_wb_sel = m.sel;   mif1.i_wb_sel = m.sel;
    mif0.i_alu_res = m.alu;  mif1.i_alu_res = m.alu;
    mif0.i_imm = m.imm;      mif1.i_imm = m.imm;
    mif0.i_funct3 = m.f3;    mif1.i_funct3 = m.f3;
    @(posedge i_clk);
    if (rs) begin
      m_valid = 1'b0; m_age = 0; m_ins = '0; m_cnt = '0;
    end else begin
      if (m_valid && m_age == 0) m_cnt = m_cnt + 64'd1;
      if (fl) begin
        m_valid = 1'b0; m_age = 0;
      end else if (st) begin
        if (m_valid) m_age = m_age + 1;
      end else begin
        m_ins = m; m_valid = m.valid; m_age = 0;
      end
    end
    #1;
    mif0.i_dmem_rdata = m_ins.rdata;
    mif1.i_dmem_rdata = m_ins.rdata;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t bub;
    ins_t junk;
    bub  = mk(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 3'd0, 32'h0);
    junk = mk(1, 1, 5'd8, 2'b00, 32'h0000_0F00, 32'h1111_1111, 32'h0, 3'd0, 32'h0);
    mif0.i_dmem_rdata = '0;
    mif1.i_dmem_rdata = '0;

    step(bub, 0, 0, 1);
    step(bub, 0, 0, 1);
    cmp_en = 1'b1;
    chk("rst_valid", 64'(o0_valid), 64'd0);
    chk("rst_wen",   64'(o0_wen),   64'd0);
    chk("rst_wdata", 64'(o0_wdata), 64'd0);
    chk("rst_pc",    64'(o0_pc),    64'd0);
    chk("rst_mis",   64'(o0_mis),   64'd0);

    // LB / LBU at offset 2 of 0x12803456
    step(mk(1, 1, 5'd5, 2'b01, 32'h100, 32'h1002, 32'h0, 3'd0, 32'h1280_3456));
    chk("lb_wdata", 64'(o0_wdata), 64'hFFFF_FF80);
    chk("lb_wen",   64'(o0_wen),   64'd1);
    chk("lb_waddr", 64'(o0_waddr), 64'd5);
    step(mk(1, 1, 5'd5, 2'b01, 32'h104, 32'h1002, 32'h0, 3'd4, 32'h1280_3456));
    chk("lbu_wdata", 64'(o1_wdata), 64'h0000_0080);
    step(bub);
    chk("lbu_one_cycle", 64'(o0_wen), 64'd0);

    // PC+4 wrap, then rd=x0
    step(mk(1, 1, 5'd1, 2'b10, 32'hFFFF_FFFC, 32'h0, 32'h0, 3'd0, 32'h0));
    chk("pc4_wdata", 64'(o0_wdata), 64'h0);
    chk("pc4_wen",   64'(o0_wen),   64'd1);
    step(mk(1, 1, 5'd0, 2'b10, 32'hFFFF_FFFC, 32'h0, 32'h0, 3'd0, 32'h0));
    chk("x0_wen", 64'(o0_wen), 64'd0);

    // ALU write held by three stall cycles
    step(mk(1, 1, 5'd7, 2'b00, 32'h200, 32'hDEAD_BEEF, 32'h0, 3'd0, 32'h0));
    chk("alu_wen",   64'(o0_wen),   64'd1);
    chk("alu_wdata", 64'(o0_wdata), 64'hDEAD_BEEF);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_before", o0_cnt, 64'd4);
`endif
    for (int i = 0; i < 3; i++) begin
      step(junk, 1);
      chk("stall_wen",   64'(o0_wen),   64'd0);
      chk("stall_valid", 64'(o0_valid), 64'd1);
      chk("stall_waddr", 64'(o0_waddr), 64'd7);
    end
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_after", o0_cnt, 64'd5);
`endif
    step(bub);

    // Flush, and flush overriding stall
    step(mk(1, 1, 5'd9, 2'b00, 32'h300, 32'h99, 32'h0, 3'd0, 32'h0), 0, 1);
    chk("flush_valid", 64'(o0_valid), 64'd0);
    chk("flush_wen",   64'(o0_wen),   64'd0);
    step(mk(1, 1, 5'd10, 2'b00, 32'h304, 32'hA0A0_A0A0, 32'h0, 3'd0, 32'h0));
    chk("pre_fs_wen", 64'(o0_wen), 64'd1);
    step(mk(1, 1, 5'd11, 2'b00, 32'h308, 32'h0B0B_0B0B, 32'h0, 3'd0, 32'h0), 1, 1);
    chk("fs_valid", 64'(o0_valid), 64'd0);
    chk("fs_wen",   64'(o0_wen),   64'd0);

    // LW at offset 2: flagged only in the checking build
    step(mk(1, 1, 5'd12, 2'b01, 32'h400, 32'h2002, 32'h0, 3'd2, 32'hCAFE_F00D));
    chk("lw_mis0",   64'(o0_mis),   64'd1);
    chk("lw_wen0",   64'(o0_wen),   64'd0);
    chk("lw_mis1",   64'(o1_mis),   64'd0);
    chk("lw_wdata1", 64'(o1_wdata), 64'hCAFE_F00D);
    step(junk, 1);
    chk("lw_mis_pulse", 64'(o0_mis), 64'd0);
    step(bub);

    // LH offset 1 -> bytes [2:1] sign-extended when unchecked
    step(mk(1, 1, 5'd13, 2'b01, 32'h500, 32'h3001, 32'h0, 3'd1, 32'h1280_3456));
    chk("lh1_wdata1", 64'(o1_wdata), 64'hFFFF_8034);
    chk("lh1_wen1",   64'(o1_wen),   64'd1);
    chk("lh1_mis0",   64'(o0_mis),   64'd1);
    step(mk(1, 1, 5'd14, 2'b01, 32'h504, 32'h3002, 32'h0, 3'd5, 32'h1280_3456));
    chk("lhu2_wdata", 64'(o0_wdata), 64'h0000_1280);
    step(mk(1, 1, 5'd15, 2'b01, 32'h508, 32'h3003, 32'h0, 3'd1, 32'h1280_3456));
    chk("lh3_mis1", 64'(o1_mis), 64'd1);
    step(mk(1, 1, 5'd16, 2'b01, 32'h50C, 32'h3000, 32'h0, 3'd6, 32'h8765_4321));
    chk("f3_6_wdata", 64'(o0_wdata), 64'h8765_4321);
    step(mk(1, 1, 5'd17, 2'b11, 32'h510, 32'h0, 32'hABCD_E000, 3'd0, 32'h0));
    chk("imm_wdata", 64'(o0_wdata), 64'hABCD_E000);

    // Reset while a stalled instruction is held
    step(mk(1, 1, 5'd18, 2'b00, 32'h600, 32'h77, 32'h0, 3'd0, 32'h0));
    step(junk, 1);
    step(junk, 1, 0, 1);
    chk("rs_valid", 64'(o0_valid), 64'd0);
    chk("rs_wen",   64'(o0_wen),   64'd0);
    chk("rs_waddr", 64'(o0_waddr), 64'd0);
    chk("rs_wdata", 64'(o0_wdata), 64'd0);
    chk("rs_pc",    64'(o0_pc),    64'd0);

    // Back-to-back writes
    step(mk(1, 1, 5'd3, 2'b00, 32'h700, 32'h33, 32'h0, 3'd0, 32'h0));
    chk("b2b_a_wen",   64'(o0_wen),   64'd1);
    chk("b2b_a_waddr", 64'(o0_waddr), 64'd3);
    chk("b2b_a_wdata", 64'(o0_wdata), 64'h33);
    step(mk(1, 1, 5'd4, 2'b00, 32'h704, 32'h44, 32'h0, 3'd0, 32'h0));
    chk("b2b_b_wen",   64'(o0_wen),   64'd1);
    chk("b2b_b_waddr", 64'(o0_waddr), 64'd4);
    chk("b2b_b_wdata", 64'(o0_wdata), 64'h44);
    step(bub);
    step(bub);
    @(negedge i_clk);
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
